// File: rtl/addsub_pkg.sv
// addsub_pkg: opcodes and signed saturation limits shared by addsub_pipe.
package addsub_pkg;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_ADDS, OP_SUBS} op_t;
  localparam int MAX_W = 1024;
  function automatic logic [MAX_W-1:0] sat_const(input int w, input logic neg);
    logic [MAX_W-1:0] msb;
    msb = {{(MAX_W-1){1'b0}}, 1'b1} << (w - 1);
    return neg ? msb : msb - MAX_W'(1);
  endfunction
endpackage

// File: rtl/addsub_seg.sv
// addsub_seg: one CHUNK-bit adder slice exposing carry-out and the carry into its MSB.
module addsub_seg #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             cm
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
  assign cm = a[CHUNK-1] ^ b[CHUNK-1] ^ s[CHUNK-1];
endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: carry-segmented pipelined add/sub with optional saturation and valid/ready handshake.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter bit SAT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             v,
  output logic             z,
  output logic             n
);
  localparam int CHUNK = WIDTH / STAGES;
  localparam int L = STAGES - 1;
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_const(WIDTH, 1'b0));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_const(WIDTH, 1'b1));
  if (WIDTH % STAGES != 0) begin : g_chk
    $error("addsub_pipe: WIDTH must be a multiple of STAGES");
  end
  logic adv;
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  // Stage k holds the beat feeding segment k: operands skewed forward, low sum chunks already done.
  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    logic [WIDTH-1:0] xa, xb, xs, nsum;
    logic [CHUNK-1:0] sum;
    logic             xc, xv, co, cm;
    op_t              xo;
    addsub_seg #(.CHUNK(CHUNK)) u_seg (
      .a (xa[k*CHUNK +: CHUNK]),
      .b (xb[k*CHUNK +: CHUNK]),
      .ci(xc),
      .s (sum),
      .co(co),
      .cm(cm)
    );
    assign nsum = xs | (WIDTH'(sum) << (k * CHUNK));
    if (k == 0) begin : g_in
      assign xa = a;
      assign xb = b ^ {WIDTH{op[0]}};
      assign xs = '0;
      assign xc = op[0];
      assign xv = in_valid;
      assign xo = op_t'(op);
    end else begin : g_reg
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          xv <= 1'b0;
          xa <= '0;
          xb <= '0;
          xs <= '0;
          xc <= 1'b0;
          xo <= OP_ADD;
        end else if (adv) begin
          xv <= g_seg[k-1].xv;
          xa <= g_seg[k-1].xa;
          xb <= g_seg[k-1].xb;
          xs <= g_seg[k-1].nsum;
          xc <= g_seg[k-1].co;
          xo <= g_seg[k-1].xo;
        end
    end
  end
  logic [WIDTH-1:0] res;
  logic             vr, sat;
  assign vr  = g_seg[L].cm ^ g_seg[L].co;
  assign sat = SAT_EN && g_seg[L].xo[1] && vr;
  assign res = sat ? (g_seg[L].xa[WIDTH-1] ? SMIN : SMAX) : g_seg[L].nsum;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      v         <= 1'b0;
      z         <= 1'b0;
      n         <= 1'b0;
    end else if (adv) begin
      out_valid <= g_seg[L].xv;
      result    <= res;
      cout      <= g_seg[L].co;
      v         <= vr;
      z         <= res == '0;
      n         <= res[WIDTH-1];
    end
endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: directed and randomized checks of addsub_pipe against an arithmetic reference model.
module tb_addsub_pipe;
  import addsub_pkg::*;
  typedef struct packed {logic [31:0] r; logic c, v, z, n;} exp_t;
  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic [1:0]  op = '0;
  logic        in_ready, out_valid, cout, v, z, n;
  logic [31:0] result;
  logic        in_ready0, out_valid0, cout0, v0, z0, n0;
  logic [31:0] result0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  addsub_pipe #(.WIDTH(32), .STAGES(4), .SAT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .cout(cout), .v(v), .z(z), .n(n)
  );
  addsub_pipe #(.WIDTH(32), .STAGES(4), .SAT_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .a(a), .b(b), .op(op),
    .out_valid(out_valid0), .out_ready(out_ready), .result(result0), .cout(cout0), .v(v0), .z(z0), .n(n0)
  );
  function automatic exp_t model(input logic [31:0] x, y, input logic [1:0] o, input bit sat_en);
    longint sx, sy, ex;
    logic [63:0] t;
    exp_t e;
    sx = $signed(x);
    sy = $signed(y);
    ex = o[0] ? sx - sy : sx + sy;
    t = 64'(x) + 64'(y);
    e.c = o[0] ? (x >= y) : t[32];
    e.v = ex > 64'sd2147483647 || ex < -64'sd2147483648;
    e.r = (sat_en && o[1] && e.v) ? (ex > 0 ? 32'h7FFFFFFF : 32'h80000000) : ex[31:0];
    e.z = e.r == 32'h0;
    e.n = e.r[31];
    return e;
  endfunction
  task automatic issue(input logic [31:0] ia, ib, input op_t io, output exp_t o, output logic [31:0] r0, output int lat);
    @(negedge clk);
    in_valid = 1'b1; a = ia; b = ib; op = io; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    o = {result, cout, v, z, n};
    r0 = result0;
  endtask
  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if ({result, cout, v, z, n} !== 36'h0) begin errors++; $display("FAIL reset_outputs got %h exp 0", {result, cout, v, z, n}); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_carry;
    exp_t o; logic [31:0] r0; int lat;
    issue(32'h000000FF, 32'h00000001, OP_ADD, o, r0, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL carry_latency got %0d exp 4", lat); end
    checks++; if (o !== exp_t'{32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0}) begin errors++; $display("FAIL carry_add got %h exp %h", o, exp_t'{32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0}); end
  endtask
  task automatic test_overflow;
    exp_t o; logic [31:0] r0; int lat;
    issue(32'h7FFFFFFF, 32'h00000001, OP_ADD, o, r0, lat);
    checks++; if (o !== exp_t'{32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1}) begin errors++; $display("FAIL ovf_add got %h exp %h", o, exp_t'{32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1}); end
    issue(32'h7FFFFFFF, 32'h00000001, OP_ADDS, o, r0, lat);
    checks++; if (o !== exp_t'{32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL ovf_adds got %h exp %h", o, exp_t'{32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 1'b0}); end
    checks++; if (r0 !== 32'h80000000) begin errors++; $display("FAIL ovf_adds_nosat got %h exp 80000000", r0); end
  endtask
  task automatic test_sub_sat;
    exp_t o; logic [31:0] r0; int lat;
    issue(32'h80000000, 32'h00000001, OP_SUBS, o, r0, lat);
    checks++; if (o !== exp_t'{32'h80000000, 1'b1, 1'b1, 1'b0, 1'b1}) begin errors++; $display("FAIL subs_min got %h exp %h", o, exp_t'{32'h80000000, 1'b1, 1'b1, 1'b0, 1'b1}); end
    issue(32'h80000000, 32'h00000001, OP_SUB, o, r0, lat);
    checks++; if (o !== exp_t'{32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL sub_wrap got %h exp %h", o, exp_t'{32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0}); end
  endtask
  task automatic test_zero;
    exp_t o; logic [31:0] r0; int lat;
    issue(32'h336FB7E5, 32'h336FB7E5, OP_SUB, o, r0, lat);
    checks++; if (o !== exp_t'{32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0}) begin errors++; $display("FAIL sub_zero got %h exp %h", o, exp_t'{32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0}); end
  endtask
  task automatic test_back_to_back;
    exp_t q[$];
    logic [31:0] q0[$];
    bit pat[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    int sent = 0, got = 0, cyc = 0;
    bit stall = 1'b0, acc = 1'b0;
    exp_t held;
    @(negedge clk);
    a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
    while (got < 16 && cyc < 300) begin
      out_ready = pat[cyc % 6];
      in_valid = sent < 16;
      #1;
      if (stall) begin
        checks++;
        if ({out_valid, result, cout, v, z, n} !== {1'b1, held}) begin
          errors++; $display("FAIL stall_hold got %b_%h exp 1_%h", out_valid, {result, cout, v, z, n}, held);
        end
      end
      checks++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        errors++; $display("FAIL in_ready got %b exp %b", in_ready, !(out_valid && !out_ready));
      end
      if (out_valid && out_ready) begin
        exp_t e;
        logic [31:0] e0;
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL stream_extra got %h exp none", {result, cout, v, z, n});
        end else begin
          e = q.pop_front();
          e0 = q0.pop_front();
          if ({result, cout, v, z, n} !== e || result0 !== e0) begin
            errors++; $display("FAIL stream_beat%0d got %h/%h exp %h/%h", got, {result, cout, v, z, n}, result0, e, e0);
          end
        end
        got++;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        q.push_back(model(a, b, op, 1'b1));
        q0.push_back(model(a, b, op, 1'b0).r);
        sent++;
      end
      stall = out_valid && !out_ready;
      held = {result, cout, v, z, n};
      @(negedge clk);
      cyc++;
      if (acc) begin a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3)); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got !== 16 || q.size() !== 0) begin errors++; $display("FAIL stream_count got %0d left %0d exp 16 left 0", got, q.size()); end
  endtask
  task automatic test_mid_reset;
    exp_t o; logic [31:0] r0; int lat;
    bit early = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 32'(i + 1); b = 32'h10; op = OP_ADD;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %b exp 1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", out_valid); end
    checks++; if ({result, cout, v, z, n} !== 36'h0) begin errors++; $display("FAIL midrst_outputs got %h exp 0", {result, cout, v, z, n}); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL stale_beat got 1 exp 0"); end
    issue(32'h00001234, 32'h00000021, OP_SUB, o, r0, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL post_reset_latency got %0d exp 4", lat); end
    checks++; if (o !== model(32'h00001234, 32'h00000021, OP_SUB, 1'b1)) begin errors++; $display("FAIL post_reset_beat got %h exp %h", o, model(32'h00001234, 32'h00000021, OP_SUB, 1'b1)); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    test_carry();
    test_overflow();
    test_sub_sat();
    test_zero();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
